// File: rtl/prog_lut_pipe.sv
// Programmable N-input boolean function unit: serially loaded truth table,
// valid/ready input handshake, OUT_LAT-deep result pipeline and a saturating output-toggle counter.
module prog_lut_pipe #(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned OUT_LAT = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  output logic             f,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int unsigned   TBL_SZ   = 1 << N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(TBL_SZ - 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [N_IN:0]      idx_q, idx_d;
  logic [TBL_SZ-1:0]  table_q, table_d;
  logic [OUT_LAT-1:0] vld_q, vld_d;
  logic [OUT_LAT-1:0] dat_q, dat_d;
  logic               last_f_q, last_f_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (cfg_start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
        end else if (cfg_valid && (idx_q == LAST_IDX)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:   if (cfg_start) state_d = ST_LOAD;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_busy   = (state_q == ST_LOAD);
    in_ready   = (state_q == ST_RUN) && !cfg_start;
    accept     = in_valid && in_ready;
    out_valid  = vld_q[OUT_LAT-1];
    f          = dat_q[OUT_LAT-1];
    toggle_cnt = cnt_q;
  end

  // Serial table load; a cfg_start with cfg_valid during LOAD writes index 0 in the same cycle
  always_comb begin
    idx_d   = idx_q;
    table_d = table_q;
    if (cfg_start) begin
      idx_d = '0;
      if ((state_q == ST_LOAD) && cfg_valid) begin
        table_d[0] = cfg_bit;
        idx_d      = (N_IN+1)'(1);
      end
    end else if ((state_q == ST_LOAD) && cfg_valid) begin
      table_d[idx_q[N_IN-1:0]] = cfg_bit;
      idx_d                    = idx_q + (N_IN+1)'(1);
    end
  end

  // Lookup at accept; each stage holds its data when nothing valid arrives so f keeps its last value
  always_comb begin
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = accept;
    if (accept) begin
      dat_d[0] = table_q[in_vec];
    end
    for (int unsigned i = 1; i < OUT_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // Toggle counter: cleared whenever a load begins, otherwise counts changes on out_valid
  always_comb begin
    last_f_d = last_f_q;
    cnt_d    = cnt_q;
    if (cfg_start) begin
      last_f_d = 1'b0;
      cnt_d    = '0;
    end else if (out_valid) begin
      last_f_d = f;
      if ((f != last_f_q) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      table_q  <= '0;
      vld_q    <= '0;
      dat_q    <= '0;
      last_f_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      table_q  <= table_d;
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      last_f_q <= last_f_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prog_lut_pipe.sv
// Self-checking bench for prog_lut_pipe: scoreboard of expected results (value and due cycle)
// pushed at accept time from a bench-side truth table, popped when out_valid is due.
module tb_prog_lut_pipe;
  localparam int unsigned N_IN    = 4;
  localparam int unsigned OUT_LAT = 2;
  localparam int unsigned CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic [N_IN-1:0]  in_vec = '0;
  logic             cfg_busy, in_ready, out_valid, f;
  logic [CNT_W-1:0] toggle_cnt;

  prog_lut_pipe #(.N_IN(N_IN), .OUT_LAT(OUT_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_busy(cfg_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .f(f), .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [15:0] tb_table = '0;
  logic        last_exp = 1'b0;

  always @(posedge clk) cyc++;

  // Output monitor and accept tracker, both sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        n_checks++;
        if (out_valid !== 1'b1 || f !== sb[0].f) begin
          n_fail++;
          $display("FAIL result cyc=%0d: out_valid=%b f=%b, required out_valid=1 f=%b",
                   cyc, out_valid, f, sb[0].f);
        end
        last_exp = sb[0].f;
        void'(sb.pop_front());
      end else if (out_valid === 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid cyc=%0d: out_valid=1, required 0", cyc);
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        sb.push_back('{f: tb_table[in_vec], due: cyc + OUT_LAT});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [N_IN-1:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
  endtask

  task automatic start_load(input logic with_bit, input logic b);
    cfg_start = 1'b1;
    cfg_valid = with_bit;
    cfg_bit   = b;
    if (with_bit) tb_table[0] = b;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_on_start: in_ready=%b, required 0", in_ready);
    end
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic shift_bits(input logic [15:0] tbl, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cfg_valid   = 1'b1;
      cfg_bit     = tbl[i];
      tb_table[i] = tbl[i];
      @(negedge clk);
      n_checks++;
      if (cfg_busy !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_bit%0d: cfg_busy=%b in_ready=%b, required 1 0", i, cfg_busy, in_ready);
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  task automatic check_run_entry(input string name);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b cfg_busy=%b, required 1 0", name, in_ready, cfg_busy);
    end
    tick();
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp);
    @(negedge clk);
    n_checks++;
    if (toggle_cnt !== exp) begin
      n_fail++;
      $display("FAIL %s: toggle_cnt=%0d, required %0d", name, toggle_cnt, exp);
    end
  endtask

  task automatic drain;
    in_valid = 1'b0;
    for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    #3;
    n_checks++;
    if ({out_valid, f, in_ready, cfg_busy, toggle_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ov=%b f=%b rdy=%b busy=%b cnt=%0d, required all 0",
               out_valid, f, in_ready, cfg_busy, toggle_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // Stimulus in EMPTY must be ignored
    in_valid  = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || cfg_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_idle: in_ready=%b cfg_busy=%b, required 0 0", in_ready, cfg_busy);
      end
      tick();
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_load;
    start_load(1'b0, 1'b0);
    shift_bits(16'hF888, 0, 15);
    check_run_entry("ready_after_load");
  endtask

  task automatic test_back_to_back;
    send_vec(4'b1010);
    send_vec(4'b0001);
    send_vec(4'b1110);
    send_vec(4'b1001);
    drain();
    check_cnt("toggle_b2b", 2);
  endtask

  task automatic test_stall;
    logic [N_IN-1:0] vecs[5];
    vecs = '{4'b0011, 4'b0100, 4'b1101, 4'b0000, 4'b0111};
    foreach (vecs[j]) begin
      send_vec(vecs[j]);
      in_valid = 1'b0;
      repeat (2) begin
        @(negedge clk);
        #1;
        if (out_valid === 1'b0) begin
          n_checks++;
          if (f !== last_exp) begin
            n_fail++;
            $display("FAIL f_hold: f=%b, required %b", f, last_exp);
          end
        end
        @(posedge clk);
        #1;
      end
    end
    drain();
    check_cnt("toggle_stall_sat", 3);
  endtask

  task automatic test_reload_overlap;
    send_vec(4'b1110);
    start_load(1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (toggle_cnt !== '0 || cfg_busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_entry: cnt=%0d busy=%b rdy=%b, required 0 1 0", toggle_cnt, cfg_busy, in_ready);
    end
    tick();
    in_valid = 1'b0;
    shift_bits(16'h0000, 0, 15);
    check_run_entry("ready_after_reload");
    check_cnt("toggle_after_drain", 1);
    tick();
    send_vec(4'b1110);
    send_vec(4'b1111);
    drain();
    check_cnt("toggle_new_table", 2);
  endtask

  task automatic test_restart_saturate;
    start_load(1'b0, 1'b0);
    shift_bits(16'hFFFF, 0, 4);
    start_load(1'b1, 1'b0);
    shift_bits(16'hAAAA, 1, 15);
    check_run_entry("ready_after_restart");
    for (int v = 0; v < 8; v++) send_vec(N_IN'(v & 1));
    drain();
    check_cnt("toggle_saturate", 3);
  endtask

  task automatic test_reset_midpipe;
    send_vec(4'b0011);
    send_vec(4'b0001);
    in_valid = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, f, in_ready, cfg_busy, toggle_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: ov=%b f=%b rdy=%b busy=%b cnt=%0d, required all 0",
               out_valid, f, in_ready, cfg_busy, toggle_cnt);
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || cfg_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle: in_ready=%b cfg_busy=%b, required 0 0", in_ready, cfg_busy);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_reload_overlap();
    test_restart_saturate();
    test_reset_midpipe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
